// File: rtl/counter_pkg.sv
// counter_pkg: mode and ONESHOT state encodings shared by the mode counter files.
package counter_pkg;
    localparam logic [1:0] M_WRAP     = 2'd0;
    localparam logic [1:0] M_SAT      = 2'd1;
    localparam logic [1:0] M_ONESHOT  = 2'd2;
    localparam logic [1:0] M_PINGPONG = 2'd3;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/counter_step.sv
// counter_step: combinational next-value, bound-hit and wrap-pulse logic for one counter step.
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       i_mode,
    input  logic             i_down,
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    output logic [WIDTH-1:0] o_next,
    output logic             o_hit,
    output logic             o_bounce
);
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_stepped;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_lo_step;
    logic             w_oor;
    logic             w_cross;
    logic             w_reach;
    assign w_step    = (i_step == '0) ? WIDTH'(1) : i_step;
    // One extra bit so up overflow and down underflow never alias back into range.
    assign w_sum     = {1'b0, i_count} + {1'b0, w_step};
    assign w_lo_step = {1'b0, i_lo} + {1'b0, w_step};
    assign w_oor     = (i_count < i_lo) | (i_count > i_hi);
    assign w_cross   = w_oor | (i_down ? ({1'b0, i_count} < w_lo_step) : (w_sum > {1'b0, i_hi}));
    assign w_reach   = i_down ? ({1'b0, i_count} == w_lo_step) : (w_sum == {1'b0, i_hi});
    assign w_stepped = i_down ? i_count - w_step : w_sum[WIDTH-1:0];
    assign o_hit     = w_cross | w_reach;
    always_comb begin
        o_next   = (i_mode == M_WRAP) ? (w_cross ? (i_down ? i_hi : i_lo) : w_stepped)
                                      : (o_hit ? (i_down ? i_lo : i_hi) : w_stepped);
        o_bounce = (i_mode == M_WRAP) ? w_cross : (i_mode == M_SAT) ? 1'b0 : o_hit;
    end
endmodule

// File: rtl/mode_counter.sv
// mode_counter: bounded up/down counter with wrap, saturate, oneshot and ping-pong modes.
module mode_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             dir_down,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);
    logic [WIDTH-1:0] r_count   = RESET_VALUE;
    logic [1:0]       r_state   = S_IDLE;
    logic             r_pp_down = 1'b0;
    logic             r_wrap    = 1'b0;
    logic [WIDTH-1:0] w_next;
    logic [1:0]       w_state_nx;
    logic             w_down;
    logic             w_hit;
    logic             w_bounce;
    logic             w_abort;
    logic             w_adv;
    counter_step #(.WIDTH(WIDTH)) u_step (
        .i_mode   (mode),
        .i_down   (w_down),
        .i_count  (r_count),
        .i_step   (step),
        .i_lo     (lo),
        .i_hi     (hi),
        .o_next   (w_next),
        .o_hit    (w_hit),
        .o_bounce (w_bounce)
    );
    assign w_down  = (mode == M_PINGPONG) ? r_pp_down : dir_down;
    assign w_abort = (mode != M_ONESHOT) & (r_state != S_IDLE);
    // A step is taken only when nothing of higher priority claims the cycle.
    assign w_adv   = enable & ~load & ~cfg_err & ~w_abort & ((mode != M_ONESHOT) | (r_state == S_RUN));
    assign cfg_err = lo > hi;
    assign tc      = w_adv & w_hit;
    assign count   = r_count;
    assign wrap    = r_wrap;
    assign busy    = r_state == S_RUN;
    assign done    = r_state == S_DONE;
    always_comb begin
        w_state_nx = (cfg_err | w_abort) ? S_IDLE :
                     (mode != M_ONESHOT) ? r_state :
                     (r_state == S_IDLE) ? (start ? S_RUN : S_IDLE) :
                     (r_state == S_RUN)  ? (w_adv & w_hit ? S_DONE : S_RUN) : S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= RESET_VALUE;
            r_state   <= S_IDLE;
            r_pp_down <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap  <= w_adv & w_bounce;
            r_count <= load ? load_value : (enable & cfg_err) ? lo : w_adv ? w_next : r_count;
            if (w_adv && mode == M_PINGPONG && w_hit)
                r_pp_down <= ~r_pp_down;
            if (!load)
                r_state <= w_state_nx;
        end
    end
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: randomized scoreboard bench for mode_counter against an integer reference model.
module tb_mode_counter;
    localparam logic [7:0] RV = 8'd7;
    logic       clk = 1'b0;
    logic       reset = 1'b0, enable = 1'b0, dir_down = 1'b0, load = 1'b0, start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] step = 8'd0, lo = 8'd0, hi = 8'd0, load_value = 8'd0;
    logic [7:0] count;
    logic       tc, wrap, busy, done, cfg_err;
    logic       mon_tc, mon_cfg;

    typedef struct {
        int count;
        bit wrap;
        bit busy;
        bit done;
        bit tc;
        bit cfg;
    } exp_t;
    exp_t q[$];
    exp_t mon_x;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int m_count = RV;
    int m_phase = 0;
    bit m_up = 1'b1;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(8), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .dir_down(dir_down),
        .step(step), .lo(lo), .hi(hi), .load(load), .load_value(load_value), .start(start),
        .count(count), .tc(tc), .wrap(wrap), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    task automatic chk(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s at check %0d: got %0d expected %0d", nm, cyc, a, e);
        end
    endtask

    // Drives one cycle and predicts outputs from the counting rules in plain integers.
    task automatic drive(input bit r, input bit e, input int md, input bit dn, input int st,
                         input int l, input int h, input bit ld, input int lv, input bit s);
        exp_t x;
        int s_eff, nx, tgt, opp;
        bit down, cfgb, outside, crossed, hit, active;
        @(negedge clk);
        reset = r; enable = e; mode = md[1:0]; dir_down = dn; step = st[7:0];
        lo = l[7:0]; hi = h[7:0]; load = ld; load_value = lv[7:0]; start = s;
        s_eff   = (st == 0) ? 1 : st;
        cfgb    = l > h;
        down    = (md == 3) ? !m_up : dn;
        nx      = down ? m_count - s_eff : m_count + s_eff;
        tgt     = down ? l : h;
        opp     = down ? h : l;
        outside = m_count < l || m_count > h;
        crossed = outside || (down ? nx < l : nx > h);
        hit     = crossed || nx == tgt;
        active  = e && !ld && !cfgb && (md == 2 ? m_phase == 1 : m_phase == 0);
        x.tc    = active && hit;
        x.cfg   = cfgb;
        if (r) begin
            m_count = RV; m_phase = 0; m_up = 1'b1; m_wrap = 1'b0;
        end else begin
            m_wrap = active && (md == 0 ? crossed : (md != 1 && hit));
            if (ld) m_count = lv;
            else if (e && cfgb) m_count = l;
            else if (active) m_count = (md == 0) ? (crossed ? opp : nx) : (hit ? tgt : nx);
            if (active && md == 3 && hit) m_up = !m_up;
            if (!ld) begin
                if (cfgb || (md != 2 && m_phase != 0)) m_phase = 0;
                else if (md == 2) m_phase = (m_phase == 0) ? (s ? 1 : 0) : (m_phase == 1) ? ((active && hit) ? 2 : 1) : 0;
            end
        end
        x.count = m_count; x.wrap = m_wrap; x.busy = m_phase == 1; x.done = m_phase == 2;
        q.push_back(x);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            mon_tc = tc;
            mon_cfg = cfg_err;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                mon_x = q.pop_front();
                cyc++;
                chk("count", int'(count), mon_x.count);
                chk("wrap", int'(wrap), int'(mon_x.wrap));
                chk("busy", int'(busy), int'(mon_x.busy));
                chk("done", int'(done), int'(mon_x.done));
                chk("tc", int'(mon_tc), int'(mon_x.tc));
                chk("cfg_err", int'(mon_cfg), int'(mon_x.cfg));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int md, l, h, st;
        bit dn;
        repeat (2) drive(0, 0, 0, 0, 1, 0, 10, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 10, 0, 0, 0);
        drive(0, 0, 0, 0, 10, 20, 99, 1, 20, 0);
        repeat (10) drive(0, 1, 0, 0, 10, 20, 99, 0, 0, 0);
        drive(0, 0, 1, 1, 3, 5, 200, 1, 10, 0);
        repeat (4) drive(0, 1, 1, 1, 3, 5, 200, 0, 0, 0);
        drive(1, 0, 2, 0, 1, 0, 4, 0, 0, 0);
        drive(0, 0, 2, 0, 1, 0, 4, 1, 0, 0);
        drive(0, 0, 2, 0, 1, 0, 4, 0, 0, 1);
        repeat (8) drive(0, 1, 2, 0, 1, 0, 4, 0, 0, 0);
        drive(0, 0, 3, 0, 1, 0, 3, 1, 0, 0);
        repeat (10) drive(0, 1, 3, 0, 1, 0, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 10, 3, 255, 1, 250, 0);
        drive(0, 1, 0, 0, 10, 3, 255, 0, 0, 0);
        drive(0, 1, 0, 0, 10, 3, 255, 1, 77, 0);
        drive(0, 1, 0, 0, 1, 50, 10, 0, 0, 0);
        drive(1, 0, 2, 0, 1, 0, 9, 0, 0, 0);
        drive(0, 0, 2, 0, 1, 0, 9, 0, 0, 1);
        repeat (3) drive(0, 1, 2, 0, 1, 0, 9, 0, 0, 0);
        drive(1, 1, 2, 0, 1, 0, 9, 0, 0, 0);
        repeat (3) drive(0, 1, 2, 0, 1, 0, 9, 0, 0, 0);
        drive(0, 0, 2, 0, 1, 0, 9, 0, 0, 1);
        drive(0, 1, 2, 0, 1, 0, 9, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 0, 9, 0, 0, 0);
        for (int b = 0; b < 70; b++) begin
            md = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: begin l = $urandom_range(40, 255); h = $urandom_range(0, l - 1); end
                1: begin l = $urandom_range(150, 250); h = 255; end
                default: begin l = $urandom_range(0, 120); h = l + $urandom_range(0, 60); end
            endcase
            dn = 1'($urandom_range(0, 1));
            for (int c = 0; c < 40; c++) begin
                st = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
                if ($urandom_range(0, 19) == 0) dn = !dn;
                if ($urandom_range(0, 79) == 0) md = $urandom_range(0, 3);
                drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 8, md, dn, st, l, h,
                      $urandom_range(0, 24) == 0, $urandom_range(0, 255), $urandom_range(0, 4) == 0);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
